// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
// Contents:
//   arb_state_t         - IDLE / BUSY / RELEASE state encoding
//   DEF_BURST_LEN       - default beats per cache-line burst
//   DEF_WORD_OFFSET     - default beat-index width, log2(DEF_BURST_LEN)
//   MAX_REQ             - largest supported requester count
//   idx_to_onehot()     - builds a MAX_REQ-wide one-hot vector from an index
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_WORD_OFFSET = 2;
    localparam int MAX_REQ         = 4;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Selects the first set request bit scanning upward from rr_ptr, wrapping
// modulo N_REQ.
// Ports:
//   req         in  N_REQ  request vector
//   rr_ptr      in  IDX_W  index with highest priority this round
//   gnt_onehot  out N_REQ  one-hot winner (all zero when nothing requests)
//   gnt_idx     out IDX_W  binary index of the winner
//   any_req     out 1      at least one request is pending
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    // cand[k] is the requester index with priority rank k this round.
    logic [IDX_W-1:0]   cand [N_REQ];
    logic [MAX_REQ-1:0] onehot_full;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand[gi] = (int'(rr_ptr) + gi >= N_REQ)
                        ? IDX_W'(int'(rr_ptr) + gi - N_REQ)
                        : IDX_W'(int'(rr_ptr) + gi);
    end

    // Walk from lowest to highest priority so the highest-priority hit is
    // the last one written.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt_idx = cand[k];
                any_req = 1'b1;
            end
        end
    end

    assign onehot_full = idx_to_onehot(2'(gnt_idx));
    assign gnt_onehot  = any_req ? onehot_full[N_REQ-1:0] : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one external memory port
// between N_REQ cache controllers. Each grant covers one burst of BURST_LEN
// beats; the grant is held until the owner drops its request afterwards.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   req_cc2arb     per-requester request
//   adr_cc2arb     packed per-requester addresses (slice i = requester i)
//   rdwr_cc2arb    per-requester direction, 0 = read, 1 = write-back
//   dat_cc2arb     packed per-requester write data
//   ack_arb2cc     per-requester beat ack (owner only)
//   dat_arb2cc     read beat data, broadcast
//   word_arb2cc    index of the current beat
//   gnt_arb2cc     one-hot grant
//   req_arb2mem    memory request
//   adr_arb2mem    address / direction / write data of the owner
//   rdwr_arb2mem
//   dat_arb2mem
//   ack_mem2arb    memory beat ack
//   dat_mem2arb    memory read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int WORD_OFFSET = DEF_WORD_OFFSET
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_cc2arb,
    input  logic [N_REQ*ADR_WIDTH-1:0]  adr_cc2arb,
    input  logic [N_REQ-1:0]            rdwr_cc2arb,
    input  logic [N_REQ*DATA_WIDTH-1:0] dat_cc2arb,
    output logic [N_REQ-1:0]            ack_arb2cc,
    output logic [DATA_WIDTH-1:0]       dat_arb2cc,
    output logic [WORD_OFFSET-1:0]      word_arb2cc,
    output logic [N_REQ-1:0]            gnt_arb2cc,
    output logic                        req_arb2mem,
    output logic [ADR_WIDTH-1:0]        adr_arb2mem,
    output logic                        rdwr_arb2mem,
    output logic [DATA_WIDTH-1:0]       dat_arb2mem,
    input  logic                        ack_mem2arb,
    input  logic [DATA_WIDTH-1:0]       dat_mem2arb
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [WORD_OFFSET-1:0] LAST_BEAT = WORD_OFFSET'(BURST_LEN - 1);

    arb_state_t             state_reg,    state_next;
    logic [N_REQ-1:0]       gnt_reg,      gnt_next;
    logic [IDX_W-1:0]       gnt_idx_reg,  gnt_idx_next;
    logic [WORD_OFFSET-1:0] beat_cnt_reg, beat_cnt_next;
    logic [IDX_W-1:0]       rr_ptr_reg,   rr_ptr_next;
    logic                   req_reg,      req_next;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             busy;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req_cc2arb),
        .rr_ptr     (rr_ptr_reg),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any_req    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
            req_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            beat_cnt_reg <= beat_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            req_reg      <= req_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        beat_cnt_next = beat_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        req_next      = req_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_next      = pick_onehot;
                    gnt_idx_next  = pick_idx;
                    beat_cnt_next = '0;
                    req_next      = 1'b1;
                    state_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ack_mem2arb) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        req_next      = 1'b0;
                        state_next    = ST_RELEASE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + WORD_OFFSET'(1);
                    end
                end
            end
            ST_RELEASE: begin
                // Wait for the owner to drop its request so the stale
                // request of the finished burst is never re-granted.
                if (!req_cc2arb[gnt_idx_reg]) begin
                    gnt_next    = '0;
                    rr_ptr_next = (gnt_idx_reg == IDX_W'(N_REQ - 1))
                                ? '0 : gnt_idx_reg + IDX_W'(1);
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_BUSY);

    // Acks outside BUSY are strays and are never forwarded.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign ack_arb2cc[gi] = busy & ack_mem2arb & (gnt_idx_reg == IDX_W'(gi));
    end

    assign adr_arb2mem  = busy ? adr_cc2arb[gnt_idx_reg*ADR_WIDTH +: ADR_WIDTH]  : '0;
    assign dat_arb2mem  = busy ? dat_cc2arb[gnt_idx_reg*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rdwr_arb2mem = busy & rdwr_cc2arb[gnt_idx_reg];
    assign dat_arb2cc   = busy ? dat_mem2arb : '0;
    assign word_arb2cc  = beat_cnt_reg;
    assign gnt_arb2cc   = gnt_reg;
    assign req_arb2mem  = req_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (N_REQ=2, BURST_LEN=4).
// A transaction-level model (owner, phase, beats done, next priority)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int WO = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_cc2arb = '0;
    logic [N*AW-1:0] adr_cc2arb = '0;
    logic [N-1:0]    rdwr_cc2arb = '0;
    logic [N*DW-1:0] dat_cc2arb = '0;
    logic [N-1:0]    ack_arb2cc;
    logic [DW-1:0]   dat_arb2cc;
    logic [WO-1:0]   word_arb2cc;
    logic [N-1:0]    gnt_arb2cc;
    logic            req_arb2mem;
    logic [AW-1:0]   adr_arb2mem;
    logic            rdwr_arb2mem;
    logic [DW-1:0]   dat_arb2mem;
    logic            ack_mem2arb = 1'b0;
    logic [DW-1:0]   dat_mem2arb = '0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .N_REQ(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .WORD_OFFSET(WO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_cc2arb(req_cc2arb), .adr_cc2arb(adr_cc2arb),
        .rdwr_cc2arb(rdwr_cc2arb), .dat_cc2arb(dat_cc2arb),
        .ack_arb2cc(ack_arb2cc), .dat_arb2cc(dat_arb2cc),
        .word_arb2cc(word_arb2cc), .gnt_arb2cc(gnt_arb2cc),
        .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
        .rdwr_arb2mem(rdwr_arb2mem), .dat_arb2mem(dat_arb2mem),
        .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = no owner, 1 = burst in progress, 2 = burst done, owner
    // still holding its request.
    int m_phase = 0;
    int m_owner = 0;
    int m_beats = 0;
    int m_next  = 0;
    int m_found = 0;
    int grant_log[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_beats = 0; m_next = 0;
        end else begin
            case (m_phase)
                0: if (req_cc2arb != '0) begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (m_found == 0 && req_cc2arb[(m_next + k) % N]) begin
                            m_owner = (m_next + k) % N;
                            m_found = 1;
                        end
                    end
                    m_phase = 1;
                    m_beats = 0;
                    grant_log.push_back(m_owner);
                end
                1: if (ack_mem2arb) begin
                    m_beats++;
                    if (m_beats == BL) begin
                        m_beats = 0;
                        m_phase = 2;
                    end
                end
                default: if (!req_cc2arb[m_owner]) begin
                    m_phase = 0;
                    m_next  = (m_owner + 1) % N;
                end
            endcase
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("gnt", 64'(gnt_arb2cc), (m_phase != 0) ? 64'(1) << m_owner : 64'(0));
        check("req_mem", 64'(req_arb2mem), 64'(m_phase == 1));
        check("ack_cc", 64'(ack_arb2cc),
              (m_phase == 1 && ack_mem2arb) ? 64'(1) << m_owner : 64'(0));
        check("word", 64'(word_arb2cc), 64'(m_beats));
        if (m_phase == 1) begin
            check("adr_mem", 64'(adr_arb2mem), 64'(adr_cc2arb[m_owner*AW +: AW]));
            check("rdwr_mem", 64'(rdwr_arb2mem), 64'(rdwr_cc2arb[m_owner]));
            check("dat_mem", 64'(dat_arb2mem), 64'(dat_cc2arb[m_owner*DW +: DW]));
            check("dat_cc", 64'(dat_arb2cc), 64'(dat_mem2arb));
        end else begin
            check("adr_mem_idle", 64'(adr_arb2mem), 64'(0));
            check("rdwr_mem_idle", 64'(rdwr_arb2mem), 64'(0));
            check("dat_mem_idle", 64'(dat_arb2mem), 64'(0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve a burst for owner r: one ack every 'gap' cycles; after the
    // last ack, hold the request 'hold' more cycles (pulsing stray acks),
    // then drop it.
    task automatic run_burst(input int r, input int gap, input logic [31:0] rd_data,
                             input int hold, input logic [31:0] wr_base);
        for (int b = 0; b < BL; b++) begin
            repeat (gap - 1) tick();
            ack_mem2arb = 1'b1;
            dat_mem2arb = rd_data;
            #1;
            check("beat_word", 64'(word_arb2cc), 64'(b));
            check("beat_ack", 64'(ack_arb2cc), 64'(1) << r);
            check("beat_rdata", 64'(dat_arb2cc), 64'(rd_data));
            if (rdwr_cc2arb[r]) begin
                check("wb_data", 64'(dat_arb2mem), 64'(wr_base + 32'(b)));
                check("wb_rdwr", 64'(rdwr_arb2mem), 64'(1));
            end
            tick();
            ack_mem2arb = 1'b0;
            if (rdwr_cc2arb[r]) dat_cc2arb[r*DW +: DW] = wr_base + 32'(b + 1);
        end
        check("req_fall", 64'(req_arb2mem), 64'(0));
        for (int h = 0; h < hold; h++) begin
            tick();
            ack_mem2arb = 1'b1;
            #1;
            check("stale_gnt", 64'(gnt_arb2cc), 64'(1) << r);
            check("stale_req", 64'(req_arb2mem), 64'(0));
            check("stale_ack", 64'(ack_arb2cc), 64'(0));
        end
        ack_mem2arb = 1'b0;
        req_cc2arb[r] = 1'b0;
        $display("burst done: requester %0d rdwr %0d beats %0d", r, rdwr_cc2arb[r], BL);
    endtask

    int exp_log[8] = '{0, 1, 0, 0, 1, 0, 0, 0};

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_gnt", 64'(gnt_arb2cc), 64'(0));
        check("rst_req", 64'(req_arb2mem), 64'(0));
        check("rst_word", 64'(word_arb2cc), 64'(0));

        // Contention: both request together, rr_ptr = 0 after reset.
        adr_cc2arb = {32'h2000_0040, 32'h1000_0000};
        req_cc2arb = 2'b11;
        #1 check("cont_latency", 64'(req_arb2mem), 64'(0));
        tick();
        check("cont_gnt0", 64'(gnt_arb2cc), 64'(2'b01));
        run_burst(0, 1, 32'h1111_1111, 0, 32'h0);
        tick();
        check("cont_release_idle", 64'(gnt_arb2cc), 64'(0));
        tick();
        check("cont_gnt1", 64'(gnt_arb2cc), 64'(2'b10));
        run_burst(1, 2, 32'h2222_2222, 0, 32'h0);
        tick();

        // Single read.
        adr_cc2arb[0 +: AW] = 32'hFF07_BD08;
        req_cc2arb = 2'b01;
        #1 check("rd_latency0", 64'(req_arb2mem), 64'(0));
        tick();
        check("rd_req_rise", 64'(req_arb2mem), 64'(1));
        check("rd_adr", 64'(adr_arb2mem), 64'(32'hFF07_BD08));
        run_burst(0, 2, 32'hFFFF_FFFF, 0, 32'h0);
        tick();

        // Stale request held 3 cycles past the last ack.
        req_cc2arb = 2'b01;
        tick();
        run_burst(0, 1, 32'h3333_3333, 3, 32'h0);
        tick();
        check("stale_exit", 64'(gnt_arb2cc), 64'(0));

        // Write-back from requester 1.
        rdwr_cc2arb = 2'b10;
        dat_cc2arb[DW +: DW] = 32'hAAAA_AAAA;
        req_cc2arb = 2'b10;
        tick();
        check("wb_gnt", 64'(gnt_arb2cc), 64'(2'b10));
        run_burst(1, 1, 32'h4444_4444, 0, 32'hAAAA_AAAA);
        tick();
        rdwr_cc2arb = 2'b00;

        // Stray ack while idle.
        ack_mem2arb = 1'b1;
        #1;
        check("stray_ack", 64'(ack_arb2cc), 64'(0));
        check("stray_word", 64'(word_arb2cc), 64'(0));
        tick();
        ack_mem2arb = 1'b0;
        tick();
        check("stray_word_after", 64'(word_arb2cc), 64'(0));
        req_cc2arb = 2'b01;
        tick();
        run_burst(0, 1, 32'h5555_5555, 0, 32'h0);
        tick();

        // Reset in the middle of a burst.
        req_cc2arb = 2'b01;
        tick();
        ack_mem2arb = 1'b1; tick();
        ack_mem2arb = 1'b0; tick();
        ack_mem2arb = 1'b1; tick();
        ack_mem2arb = 1'b0;
        check("mid_word2", 64'(word_arb2cc), 64'(2));
        rst = 1'b1;
        #1;
        check("arst_gnt", 64'(gnt_arb2cc), 64'(0));
        check("arst_req", 64'(req_arb2mem), 64'(0));
        check("arst_word", 64'(word_arb2cc), 64'(0));
        check("arst_adr", 64'(adr_arb2mem), 64'(0));
        req_cc2arb = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        req_cc2arb = 2'b01;
        tick();
        check("post_rst_gnt", 64'(gnt_arb2cc), 64'(2'b01));
        check("post_rst_word", 64'(word_arb2cc), 64'(0));
        run_burst(0, 1, 32'h6666_6666, 0, 32'h0);
        tick();
        tick();

        // Pin the model's grant order to the hand-derived sequence.
        check("log_len", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("log_order", 64'(grant_log[i]), 64'(exp_log[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
